// File: rtl/l1i_cache_assoc_if.sv
// l1i_cache_assoc_if
// Bundles the two buses of the L1 instruction cache:
//   - core fetch side: core_req, core_addr, core_out, core_wait, flush
//   - memory side (I_* bus): I_req, I_addr, I_out, I_wait, I_write, I_type
// modport slave  : the cache's view (fetch requests in, memory reads out)
// modport master : the environment's view (CPU core plus instruction memory)
interface l1i_cache_assoc_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_out;
    logic              core_wait;
    logic              flush;

    logic              I_req;
    logic [ADDR_W-1:0] I_addr;
    logic [DATA_W-1:0] I_out;
    logic              I_wait;
    logic              I_write;
    logic [2:0]        I_type;

    modport slave (
        input  core_req, core_addr, flush, I_out, I_wait,
        output core_out, core_wait, I_req, I_addr, I_write, I_type
    );

    modport master (
        output core_req, core_addr, flush, I_out, I_wait,
        input  core_out, core_wait, I_req, I_addr, I_write, I_type
    );
endinterface

// File: rtl/l1i_cache_assoc.sv
// l1i_cache_assoc
// Read-only N-way set-associative L1 instruction cache. Tag/valid/data are
// register arrays read combinationally, so a hit answers in the request cycle.
// A miss refills a whole line from the I_* bus (FILL), writes it into the
// victim way (COMMIT) and lets the still-held request hit. Victim choice is
// the lowest invalid way, otherwise a per-set round-robin pointer.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : core fetch port + flush, and the I_* memory read port
//   access_cnt   : accepted fetches, saturating
//   miss_cnt     : refills started, saturating
module l1i_cache_assoc #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    l1i_cache_assoc_if.slave  bus,
    output logic [CNT_W-1:0]  access_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [2:0] CACHE_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t state_r, state_s;

    logic [TAG_W-1:0]  tag_mem_r  [WAYS][SETS];
    logic              valid_r    [WAYS][SETS];
    logic [DATA_W-1:0] data_mem_r [WAYS][SETS][WORDS];
    logic [WAY_W-1:0]  rr_r       [SETS];
    logic [DATA_W-1:0] line_r     [WORDS];

    logic [OFF_W-1:0]  beat_r;
    logic [TAG_W-1:0]  fill_tag_r;
    logic [IDX_W-1:0]  fill_idx_r;
    logic [WAY_W-1:0]  victim_r;
    logic              victim_rr_r;
    logic              flush_pend_r;

    logic [TAG_W-1:0]  tag_s;
    logic [IDX_W-1:0]  idx_s;
    logic [OFF_W-1:0]  word_s;
    logic              unused_s;
    logic              hit_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic [WAY_W-1:0]  victim_s;
    logic              victim_rr_s;
    logic              core_wait_s;
    logic              start_fill_s;
    logic              beat_ok_s;
    logic              access_s;

    assign tag_s    = bus.core_addr[ADDR_W-1 -: TAG_W];
    assign idx_s    = bus.core_addr[2+OFF_W +: IDX_W];
    assign word_s   = bus.core_addr[2 +: OFF_W];
    // Byte-within-word bits carry no information for word fetches.
    assign unused_s = ^bus.core_addr[1:0];

    // Tag compare across all ways of the indexed set.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_s     = hit_s | (valid_r[w][idx_s] && (tag_mem_r[w][idx_s] == tag_s));
            hit_way_s = (valid_r[w][idx_s] && (tag_mem_r[w][idx_s] == tag_s)) ? WAY_W'(w) : hit_way_s;
        end
    end

    // Victim: scan downwards so the lowest invalid way wins; fall back to rr_ptr.
    always_comb begin
        victim_s    = rr_r[idx_s];
        victim_rr_s = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            victim_s    = valid_r[w][idx_s] ? victim_s : WAY_W'(w);
            victim_rr_s = victim_rr_s & valid_r[w][idx_s];
        end
    end

    // Stall: only IDLE can answer, and a flush in IDLE blocks even a hit.
    always_comb begin
        core_wait_s = 1'b0;
        if (!bus.core_req) begin
            core_wait_s = 1'b0;
        end else if (state_r == IDLE) begin
            core_wait_s = ~hit_s | bus.flush;
        end else begin
            core_wait_s = 1'b1;
        end
    end

    // Next-state logic; flush has priority over a miss in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.flush) begin
                    state_s = FLUSH;
                end else if (bus.core_req && !hit_s) begin
                    state_s = FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (!bus.I_wait && (beat_r == OFF_W'(WORDS - 1))) begin
                    state_s = COMMIT;
                end else begin
                    state_s = FILL;
                end
            end
            COMMIT: begin
                if (flush_pend_r || bus.flush) begin
                    state_s = FLUSH;
                end else begin
                    state_s = IDLE;
                end
            end
            FLUSH:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    assign start_fill_s = (state_r == IDLE) && (state_s == FILL);
    assign beat_ok_s    = (state_r == FILL) && !bus.I_wait;
    assign access_s     = bus.core_req & ~core_wait_s;

    assign bus.core_wait = core_wait_s;
    assign bus.core_out  = hit_s ? data_mem_r[hit_way_s][idx_s][word_s] : '0;
    assign bus.I_req     = (state_r == FILL);
    assign bus.I_addr    = (state_r == FILL) ? {fill_tag_r, fill_idx_r, beat_r, 2'b00} : '0;
    assign bus.I_write   = 1'b0;
    assign bus.I_type    = CACHE_WORD;

    // Control state: FSM, refill bookkeeping, pending flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            beat_r       <= '0;
            fill_tag_r   <= '0;
            fill_idx_r   <= '0;
            victim_r     <= '0;
            victim_rr_r  <= 1'b0;
            flush_pend_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_fill_s) begin
                beat_r      <= '0;
                fill_tag_r  <= tag_s;
                fill_idx_r  <= idx_s;
                victim_r    <= victim_s;
                victim_rr_r <= victim_rr_s;
            end else if (beat_ok_s) begin
                beat_r <= beat_r + 1'b1;
            end
            if (state_r == FLUSH) begin
                flush_pend_r <= 1'b0;
            end else if (bus.flush && ((state_r == FILL) || (state_r == COMMIT))) begin
                flush_pend_r <= 1'b1;
            end
        end
    end

    // Valid bits and round-robin pointers: cleared by reset, valid also by FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                rr_r[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[w][s] <= 1'b0;
                end
            end
        end else if (state_r == FLUSH) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[w][s] <= 1'b0;
                end
            end
        end else if (state_r == COMMIT) begin
            valid_r[victim_r][fill_idx_r] <= 1'b1;
            // Only a round-robin eviction advances the pointer.
            if (victim_rr_r) begin
                rr_r[fill_idx_r] <= (rr_r[fill_idx_r] == WAY_W'(WAYS - 1)) ? '0 : rr_r[fill_idx_r] + 1'b1;
            end
        end
    end

    // Line buffer capture and array write on COMMIT; contents gated by valid_r.
    always_ff @(posedge clk) begin
        if (beat_ok_s) begin
            line_r[beat_r] <= bus.I_out;
        end
        if (state_r == COMMIT) begin
            tag_mem_r[victim_r][fill_idx_r] <= fill_tag_r;
            for (int k = 0; k < WORDS; k++) begin
                data_mem_r[victim_r][fill_idx_r][k] <= line_r[k];
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            access_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (access_s && (access_cnt != '1)) begin
                access_cnt <= access_cnt + 1'b1;
            end
            if (start_fill_s && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_l1i_cache_assoc.sv
// tb_l1i_cache_assoc
// Directed bench for l1i_cache_assoc (WAYS=2, SETS=64, WORDS=4). The bench
// plays both CPU core and instruction memory; memory word at byte address a
// is {16'hC0DE, a[15:0]}.
module tb_l1i_cache_assoc;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] access_cnt;
    logic [31:0] miss_cnt;
    int          n_chk = 0;
    int          n_err = 0;
    int          exp_acc = 0;
    int          exp_miss = 0;

    l1i_cache_assoc_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    l1i_cache_assoc #(
        .ADDR_W(32), .DATA_W(32), .WAYS(2), .SETS(64), .WORDS(4), .CNT_W(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .access_cnt (access_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign bus.I_out = mem_word(bus.I_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full cold-miss sequence with I_wait=0; ends in the hit cycle, request held.
    task automatic fetch_miss(input logic [31:0] a);
        cyc();
        bus.core_req  = 1'b1;
        bus.core_addr = a;
        #1;
        chk("miss_acc_before", access_cnt, exp_acc);
        chk("miss_cnt_before", miss_cnt, exp_miss);
        chk("miss_wait", {31'd0, bus.core_wait}, 32'd1);
        chk("miss_out_zero", bus.core_out, 32'd0);
        exp_miss++;
        for (int b = 0; b < 4; b++) begin
            cyc();
            #1;
            chk("fill_req", {31'd0, bus.I_req}, 32'd1);
            chk("fill_addr", bus.I_addr, {a[31:4], b[1:0], 2'b00});
        end
        chk("miss_cnt_after", miss_cnt, exp_miss);
        cyc();
        #1;
        chk("commit_req", {31'd0, bus.I_req}, 32'd0);
        chk("commit_wait", {31'd0, bus.core_wait}, 32'd1);
        cyc();
        #1;
        chk("refill_hit_wait", {31'd0, bus.core_wait}, 32'd0);
        chk("refill_hit_data", bus.core_out, mem_word(a));
        exp_acc++;
    endtask

    // Expected hit: answered in the request cycle.
    task automatic fetch_hit(input logic [31:0] a, input logic [31:0] exp_data);
        cyc();
        bus.core_req  = 1'b1;
        bus.core_addr = a;
        #1;
        chk("hit_acc_before", access_cnt, exp_acc);
        chk("hit_wait", {31'd0, bus.core_wait}, 32'd0);
        chk("hit_data", bus.core_out, exp_data);
        exp_acc++;
    endtask

    // Expected miss probe; request withdrawn before the edge so no refill starts.
    task automatic probe_miss(input logic [31:0] a);
        cyc();
        bus.core_req  = 1'b1;
        bus.core_addr = a;
        #1;
        chk("probe_wait", {31'd0, bus.core_wait}, 32'd1);
        chk("probe_out", bus.core_out, 32'd0);
        bus.core_req = 1'b0;
        #1;
    endtask

    task automatic idle_check();
        cyc();
        bus.core_req = 1'b0;
        #1;
        chk("idle_acc", access_cnt, exp_acc);
        chk("idle_miss", miss_cnt, exp_miss);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.core_req  = 1'b0;
        bus.core_addr = 32'd0;
        bus.flush     = 1'b0;
        bus.I_wait    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_core_wait", {31'd0, bus.core_wait}, 32'd0);
        chk("rst_I_req", {31'd0, bus.I_req}, 32'd0);
        chk("rst_I_addr", bus.I_addr, 32'd0);
        chk("rst_core_out", bus.core_out, 32'd0);
        chk("rst_access", access_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
        chk("I_write", {31'd0, bus.I_write}, 32'd0);
        chk("I_type", {29'd0, bus.I_type}, 32'd2);

        // Cold miss then the rest of the line back-to-back.
        fetch_miss(32'h0000_0100);
        fetch_hit(32'h0000_0104, 32'hC0DE_0104);
        chk("t1_acc", access_cnt, 32'd1);
        chk("t1_miss", miss_cnt, 32'd1);
        fetch_hit(32'h0000_0108, 32'hC0DE_0108);
        fetch_hit(32'h0000_010C, 32'hC0DE_010C);
        idle_check();
        chk("t2_acc", access_cnt, 32'd4);
        chk("t2_miss", miss_cnt, 32'd1);

        // Replacement in set 0: invalid ways first, then round-robin.
        fetch_miss(32'h0000_0000);
        fetch_miss(32'h0000_0400);
        fetch_miss(32'h0000_0800);
        fetch_hit(32'h0000_0404, 32'hC0DE_0404);
        fetch_miss(32'h0000_0000);
        fetch_hit(32'h0000_0808, 32'hC0DE_0808);
        probe_miss(32'h0000_0400);
        idle_check();
        chk("t3_acc", access_cnt, 32'd10);
        chk("t3_miss", miss_cnt, 32'd5);

        // Flush in IDLE on a hitting request.
        cyc();
        bus.core_req  = 1'b1;
        bus.core_addr = 32'h0000_0800;
        bus.flush     = 1'b1;
        #1;
        chk("flush_idle_wait", {31'd0, bus.core_wait}, 32'd1);
        cyc();
        bus.flush = 1'b0;
        #1;
        chk("flush_state_wait", {31'd0, bus.core_wait}, 32'd1);
        chk("flush_state_req", {31'd0, bus.I_req}, 32'd0);
        cyc();
        #1;
        chk("after_flush_miss", {31'd0, bus.core_wait}, 32'd1);
        bus.core_req = 1'b0;
        #1;
        chk("flush_no_count", access_cnt, exp_acc);

        // Two-cycle memory stall on beat 2.
        cyc();
        bus.core_req  = 1'b1;
        bus.core_addr = 32'h0000_0100;
        #1;
        chk("st_wait", {31'd0, bus.core_wait}, 32'd1);
        exp_miss++;
        cyc(); #1; chk("st_b0", bus.I_addr, 32'h0000_0100);
        cyc(); #1; chk("st_b1", bus.I_addr, 32'h0000_0104);
        cyc(); bus.I_wait = 1'b1; #1; chk("st_b2a", bus.I_addr, 32'h0000_0108);
        cyc(); #1; chk("st_b2b", bus.I_addr, 32'h0000_0108);
        cyc(); bus.I_wait = 1'b0; #1; chk("st_b2c", bus.I_addr, 32'h0000_0108);
        chk("st_req_held", {31'd0, bus.I_req}, 32'd1);
        cyc(); #1; chk("st_b3", bus.I_addr, 32'h0000_010C);
        cyc(); #1; chk("st_commit_wait", {31'd0, bus.core_wait}, 32'd1);
        cyc(); #1;
        chk("st_hit_wait", {31'd0, bus.core_wait}, 32'd0);
        chk("st_hit_data", bus.core_out, 32'hC0DE_0100);
        exp_acc++;
        fetch_hit(32'h0000_0108, 32'hC0DE_0108);
        idle_check();

        // Flush arriving during FILL beat 1: commit, flush, re-miss.
        cyc();
        bus.core_req  = 1'b1;
        bus.core_addr = 32'h0000_0200;
        #1;
        chk("fp_wait", {31'd0, bus.core_wait}, 32'd1);
        exp_miss++;
        cyc(); #1; chk("fp_b0", bus.I_addr, 32'h0000_0200);
        cyc(); bus.flush = 1'b1; #1; chk("fp_b1", bus.I_addr, 32'h0000_0204);
        cyc(); bus.flush = 1'b0; #1; chk("fp_b2", bus.I_addr, 32'h0000_0208);
        cyc(); #1; chk("fp_b3", bus.I_addr, 32'h0000_020C);
        cyc(); #1; chk("fp_commit_req", {31'd0, bus.I_req}, 32'd0);
        cyc(); #1;
        chk("fp_flush_wait", {31'd0, bus.core_wait}, 32'd1);
        chk("fp_flush_req", {31'd0, bus.I_req}, 32'd0);
        cyc(); #1;
        chk("fp_remiss_wait", {31'd0, bus.core_wait}, 32'd1);
        chk("fp_remiss_req", {31'd0, bus.I_req}, 32'd0);
        exp_miss++;
        for (int b = 0; b < 4; b++) begin
            cyc();
            #1;
            chk("fp_refill_addr", bus.I_addr, {28'h000_0020, b[1:0], 2'b00});
        end
        chk("fp_miss_twice", miss_cnt, exp_miss);
        cyc(); #1;
        cyc(); #1;
        chk("fp_hit_wait", {31'd0, bus.core_wait}, 32'd0);
        chk("fp_hit_data", bus.core_out, 32'hC0DE_0200);
        exp_acc++;
        probe_miss(32'h0000_0100);
        idle_check();

        // Reset asserted mid-FILL.
        cyc();
        bus.core_req  = 1'b1;
        bus.core_addr = 32'h0000_0300;
        #1;
        chk("rf_wait", {31'd0, bus.core_wait}, 32'd1);
        cyc(); #1; chk("rf_req_b0", {31'd0, bus.I_req}, 32'd1);
        cyc(); #1; chk("rf_b1", bus.I_addr, 32'h0000_0304);
        rst = 1'b1;
        #1;
        chk("rf_req_drop", {31'd0, bus.I_req}, 32'd0);
        chk("rf_addr_zero", bus.I_addr, 32'd0);
        chk("rf_acc_zero", access_cnt, 32'd0);
        chk("rf_miss_zero", miss_cnt, 32'd0);
        bus.core_req = 1'b0;
        cyc();
        rst      = 1'b0;
        exp_acc  = 0;
        exp_miss = 0;
        fetch_miss(32'h0000_0300);
        idle_check();
        chk("rf_final_acc", access_cnt, 32'd1);
        chk("rf_final_miss", miss_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
